// File: rtl/cpu_sequencer_if.sv
// Bus between the CPU sequencer and its environment: start/halt control, memory/datapath
// handshakes, stage enables, status and the retired-instruction count.
interface cpu_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic             fetch_ready;
  logic             exec_stall;
  logic             halt_req;
  logic [2:0]       current_state;
  logic             fetch_en;
  logic             load_en;
  logic             exec_en;
  logic             wb_en;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  start, fetch_ready, exec_stall, halt_req,
    output current_state, fetch_en, load_en, exec_en, wb_en, busy, timeout_err, retired_cnt
  );

  modport slave (
    output start, fetch_ready, exec_stall, halt_req,
    input  current_state, fetch_en, load_en, exec_en, wb_en, busy, timeout_err, retired_cnt
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE->FETCH->LOAD->EXECUTE->WRITEBACK with fetch timeout,
// stallable execute and boundary halt. Define SEQ_PERF_CNT_EN to enable the retired counter.
module cpu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned MAX_WAIT    = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.master bus
);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned EXEC_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [EXEC_W-1:0] exec_q, exec_d;
  logic              terr_q, terr_d;

  // Counters default to zero so that any state entering FETCH/EXECUTE starts them cleared.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    exec_d  = '0;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        if (bus.fetch_ready) begin
          state_d = LOAD;
        end else if (wait_q == WAIT_LAST) begin
          state_d = HALT;
          terr_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      LOAD: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (bus.exec_stall) begin
          exec_d = exec_q;
        end else if (exec_q == EXEC_LAST) begin
          state_d = WRITEBACK;
        end else begin
          exec_d = exec_q + EXEC_W'(1);
        end
      end
      WRITEBACK: begin
        state_d = bus.halt_req ? HALT : FETCH;
      end
      HALT: begin
        if (bus.start) begin
          state_d = FETCH;
          terr_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      exec_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      exec_q  <= exec_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.fetch_en      = (state_q == FETCH);
  assign bus.load_en       = (state_q == LOAD);
  assign bus.exec_en       = (state_q == EXECUTE) && !bus.exec_stall;
  assign bus.wb_en         = (state_q == WRITEBACK);
  assign bus.busy          = (state_q == FETCH) || (state_q == LOAD) ||
                             (state_q == EXECUTE) || (state_q == WRITEBACK);
  assign bus.timeout_err   = terr_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WRITEBACK) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.retired_cnt = cnt_q;
`else
  assign bus.retired_cnt = {CNT_W{1'b0}};
`endif

  a_enables_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({bus.fetch_en, bus.load_en, bus.exec_en, bus.wb_en}));

endmodule
